// File: rtl/pio_link_pkg.sv
// Shared types and constants for the PIO link responder.
// Holds the opcode set, status word bit positions and the parity helper.
package pio_link_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_WRITE  = 3'd1,
        OP_READ   = 3'd2,
        OP_CLEAR  = 3'd3,
        OP_STATUS = 3'd4,
        OP_RSV5   = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int CTRL_REQ    = 0;
    localparam int CTRL_OP_LSB = 1;
    localparam int CTRL_PAR    = 4;

    localparam int STAT_ACK     = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_TX_FULL = 2;
    localparam int STAT_RX_EMPT = 3;
    localparam int STAT_ERR_OVF = 4;
    localparam int STAT_ERR_UDF = 5;
    localparam int STAT_ERR_CMD = 6;
    localparam int STAT_ERR_PAR = 7;
    localparam int STAT_TX_CNT  = 8;
    localparam int STAT_RX_CNT  = 16;

    function automatic logic parity32(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pio_link_fifo.sv
// Synchronous word FIFO with flush and occupancy count.
// Push while full and pop while empty are ignored; flush wins over both.
module pio_link_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [7:0]       count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = 8'(count_q);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pio_link_responder.sv
// HPS PIO command responder bridging PIO words to TX/RX word streams.
// Define PIO_LINK_PARITY_EN to enable WRITE data parity checking.
module pio_link_responder
    import pio_link_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] pio_ctrl_in,
    input  logic [31:0] pio_data_in,
    output logic [31:0] pio_stat_out,
    output logic [31:0] pio_data_out,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

`ifdef PIO_LINK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   ctrl_unused;

    state_e      state_q;
    opcode_e     op_q;
    logic        par_q;
    logic [31:0] wdata_q;
    logic [31:0] dout_q;
    logic        ack_q;
    logic        req_last_q;
    logic        err_ovf_q;
    logic        err_udf_q;
    logic        err_cmd_q;
    logic        err_par_q;

    logic        exec;
    logic        par_bad;
    logic        flush;
    logic        tx_push;
    logic        rx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  tx_count;
    logic [7:0]  rx_count;
    logic [31:0] rx_head;
    logic [31:0] stat;

    assign ctrl_unused = ^pio_ctrl_in[31:5];

    // Synchronizer keeps shifting through reset so req_last sees settled data.
    always_ff @(posedge clk_clk) begin
        sync_q <= SYNC_STAGES'({sync_q, pio_ctrl_in[CTRL_REQ]});
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    assign exec    = (state_q == ST_EXEC);
    assign par_bad = PAR_EN && (par_q != parity32(wdata_q));
    assign flush   = exec && (op_q == OP_CLEAR);
    assign tx_push = exec && (op_q == OP_WRITE) && !par_bad && !tx_full;
    assign rx_pop  = exec && (op_q == OP_READ) && !rx_empty;

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    pio_link_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .flush_i (flush),
        .push_i  (tx_push),
        .wdata_i (wdata_q),
        .pop_i   (tx_valid && tx_ready),
        .rdata_o (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    pio_link_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .flush_i (flush),
        .push_i  (rx_valid && rx_ready),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            par_q      <= 1'b0;
            wdata_q    <= '0;
            dout_q     <= '0;
            ack_q      <= 1'b0;
            req_last_q <= req_s;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            err_cmd_q  <= 1'b0;
            err_par_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_s != req_last_q) begin
                        req_last_q <= req_s;
                        op_q       <= opcode_e'(pio_ctrl_in[CTRL_OP_LSB +: 3]);
                        par_q      <= pio_ctrl_in[CTRL_PAR];
                        wdata_q    <= pio_data_in;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_ACK;
                    ack_q   <= ~ack_q;
                    unique case (op_q)
                        OP_NOP: ;
                        OP_WRITE: begin
                            if (par_bad)      err_par_q <= 1'b1;
                            else if (tx_full) err_ovf_q <= 1'b1;
                        end
                        OP_READ: begin
                            dout_q <= rx_empty ? 32'h0 : rx_head;
                            if (rx_empty) err_udf_q <= 1'b1;
                        end
                        OP_CLEAR: begin
                            dout_q    <= '0;
                            err_ovf_q <= 1'b0;
                            err_udf_q <= 1'b0;
                            err_cmd_q <= 1'b0;
                            err_par_q <= 1'b0;
                        end
                        OP_STATUS: dout_q <= {16'h0, rx_count, tx_count};
                        default:   err_cmd_q <= 1'b1;
                    endcase
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stat               = '0;
        stat[STAT_ACK]     = ack_q;
        stat[STAT_BUSY]    = (state_q != ST_IDLE);
        stat[STAT_TX_FULL] = tx_full;
        stat[STAT_RX_EMPT] = rx_empty;
        stat[STAT_ERR_OVF] = err_ovf_q;
        stat[STAT_ERR_UDF] = err_udf_q;
        stat[STAT_ERR_CMD] = err_cmd_q;
        stat[STAT_ERR_PAR] = err_par_q;
        stat[STAT_TX_CNT +: 8] = tx_count;
        stat[STAT_RX_CNT +: 8] = rx_count;
    end

    assign pio_stat_out = stat;
    assign pio_data_out = dout_q;

endmodule

// File: tb/tb_pio_link_responder.sv
// Scoreboard bench for pio_link_responder against a queue-based model.
// Honours PIO_LINK_PARITY_EN in the same way as the design build.
module tb_pio_link_responder;

    localparam int DEPTH = 16;

`ifdef PIO_LINK_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] pio_ctrl_in;
    logic [31:0] pio_data_in;
    logic [31:0] pio_stat_out;
    logic [31:0] pio_data_out;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    always #5 clk_clk = ~clk_clk;

    pio_link_responder #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .pio_ctrl_in  (pio_ctrl_in),
        .pio_data_in  (pio_data_in),
        .pio_stat_out (pio_stat_out),
        .pio_data_out (pio_data_out),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready)
    );

    typedef struct {
        logic [31:0] dout;
        logic [31:0] stat;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tx_m[$];
    logic [31:0] rx_m[$];
    bit          m_ovf, m_udf, m_cmd, m_par, m_ack, req;
    logic [31:0] m_dout;
    int          tests = 0;
    int          fails = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] model_stat(bit busy);
        logic [31:0] s;
        s        = '0;
        s[0]     = m_ack;
        s[1]     = busy;
        s[2]     = (tx_m.size() == DEPTH);
        s[3]     = (rx_m.size() == 0);
        s[4]     = m_ovf;
        s[5]     = m_udf;
        s[6]     = m_cmd;
        s[7]     = m_par;
        s[15:8]  = 8'(tx_m.size());
        s[23:16] = 8'(rx_m.size());
        return s;
    endfunction

    function automatic void model_reset();
        tx_m.delete();
        rx_m.delete();
        {m_ovf, m_udf, m_cmd, m_par, m_ack} = '0;
        m_dout = '0;
    endfunction

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: pending %0d expected 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic issue(input int op, input logic [31:0] d, input bit badpar, input string nm);
        exp_t e;
        bit   par;
        par = (^d) ^ badpar;
        case (op)
            0: ;
            1: begin
                if (PAR_ON && badpar)         m_par = 1'b1;
                else if (tx_m.size() == DEPTH) m_ovf = 1'b1;
                else                           tx_m.push_back(d);
            end
            2: begin
                if (rx_m.size() == 0) begin
                    m_dout = '0;
                    m_udf  = 1'b1;
                end else begin
                    m_dout = rx_m.pop_front();
                end
            end
            3: begin
                tx_m.delete();
                rx_m.delete();
                {m_ovf, m_udf, m_cmd, m_par} = '0;
                m_dout = '0;
            end
            4: m_dout = {16'h0, 8'(rx_m.size()), 8'(tx_m.size())};
            default: m_cmd = 1'b1;
        endcase
        m_ack  = ~m_ack;
        e.dout = m_dout;
        e.stat = model_stat(1'b1);
        e.name = nm;
        sb_q.push_back(e);
        req         = ~req;
        pio_data_in = d;
        pio_ctrl_in = {27'h0, par, 3'(op), req};
        wait_done(nm);
    endtask

    task automatic rx_send(input logic [31:0] w);
        chk("rx_ready", {31'h0, rx_ready}, {31'h0, rx_m.size() < DEPTH});
        if (rx_m.size() < DEPTH) rx_m.push_back(w);
        rx_valid = 1'b1;
        rx_data  = w;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic tx_drain(input int n);
        tx_ready = 1'b1;
        repeat (n) tick();
        tx_ready = 1'b0;
    endtask

    // Monitor: ack toggles retire scoreboard entries; tx handshakes retire model words.
    initial begin : monitor
        bit   prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                prev_ack = 1'b0;
            end else begin
                if (pio_stat_out[0] !== prev_ack) begin
                    prev_ack = pio_stat_out[0];
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_ack: got ack %b with nothing pending, expected no toggle", prev_ack);
                    end else begin
                        e = sb_q.pop_front();
                        chk({e.name, "_dout"}, pio_data_out, e.dout);
                        chk({e.name, "_stat"}, pio_stat_out, e.stat);
                    end
                end
                if (sb_q.size() == 0) begin
                    chk("tx_valid", {31'h0, tx_valid}, {31'h0, tx_m.size() != 0});
                    if (tx_valid && tx_ready && tx_m.size() != 0)
                        chk("tx_data", tx_data, tx_m.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pio_ctrl_in = '0;
        pio_data_in = '0;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        req         = 1'b0;
        model_reset();
        repeat (5) tick();
        reset_reset = 1'b0;
        tick();
        chk("rst_stat", pio_stat_out, model_stat(1'b0));
        chk("rst_dout", pio_data_out, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);

        issue(1, 32'h3F800000, 1'b0, "write1");
        chk("write1_tx_data", tx_data, 32'h3F800000);
        chk("write1_tx_count", {24'h0, pio_stat_out[15:8]}, 32'd1);

        rx_send(32'h40490FDB);
        issue(2, 32'h0, 1'b0, "read1");
        chk("read1_data", pio_data_out, 32'h40490FDB);
        chk("read1_rx_empty", {31'h0, pio_stat_out[3]}, 32'h1);
        issue(2, 32'h0, 1'b0, "read2");
        chk("read2_data", pio_data_out, 32'h0);
        chk("read2_udf", {31'h0, pio_stat_out[5]}, 32'h1);
        issue(3, 32'h0, 1'b0, "clear1");

        for (int i = 0; i < 17; i++) issue(1, 32'hA000_0000 + i, 1'b0, "fill");
        chk("fill_tx_full", {31'h0, pio_stat_out[2]}, 32'h1);
        chk("fill_tx_count", {24'h0, pio_stat_out[15:8]}, 32'd16);
        chk("fill_ovf", {31'h0, pio_stat_out[4]}, 32'h1);
        tx_drain(DEPTH + 3);

        issue(6, 32'h0, 1'b0, "badop");
        chk("badop_cmd", {31'h0, pio_stat_out[6]}, 32'h1);
        issue(3, 32'h0, 1'b0, "clear2");
        chk("clear2_errs", {28'h0, pio_stat_out[7:4]}, 32'h0);
        chk("clear2_counts", {16'h0, pio_stat_out[23:8]}, 32'h0);

        issue(1, 32'h1, 1'b1, "parity");
        chk("parity_err", {31'h0, pio_stat_out[7]}, {31'h0, PAR_ON});
        chk("parity_count", {24'h0, pio_stat_out[15:8]}, PAR_ON ? 32'd0 : 32'd1);
        issue(3, 32'h0, 1'b0, "clear3");

        for (int i = 0; i < DEPTH + 1; i++) rx_send(32'hB000_0000 + i);
        issue(1, 32'h55, 1'b0, "w_mix");
        issue(4, 32'h0, 1'b0, "status");
        chk("status_data", pio_data_out, {16'h0, 8'(DEPTH), 8'd1});
        issue(0, 32'h0, 1'b0, "nop");

        req         = ~req;
        pio_data_in = 32'hDEAD_BEEF;
        pio_ctrl_in = {27'h0, ^pio_data_in, 3'd1, req};
        n = 0;
        do begin
            @(negedge clk_clk);
            n++;
        end while (!pio_stat_out[1] && n < 10);
        if (!pio_stat_out[1]) begin
            tests++;
            fails++;
            $display("FAIL rst_exec: busy never seen, got 0 expected 1");
        end
        reset_reset = 1'b1;
        model_reset();
        repeat (3) tick();
        reset_reset = 1'b0;
        repeat (8) tick();
        chk("rstmid_busy", {31'h0, pio_stat_out[1]}, 32'h0);
        chk("rstmid_ack", {31'h0, pio_stat_out[0]}, 32'h0);
        chk("rstmid_stat", pio_stat_out, model_stat(1'b0));
        chk("rstmid_dout", pio_data_out, 32'h0);

        repeat (300) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    int op;
                    op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2);
                    issue(op, $urandom, $urandom_range(0, 7) == 0, "rnd");
                end
                5, 6: rx_send($urandom);
                7, 8: tx_drain($urandom_range(1, 4));
                default: tick();
            endcase
        end

        issue(4, 32'h0, 1'b0, "final_status");
        chk("final_status_data", pio_data_out, {16'h0, 8'(rx_m.size()), 8'(tx_m.size())});
        tx_drain(DEPTH + 2);
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pio_link_responder.md
PIO_LINK_RESPONDER -- requirements
Module: pio_link_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, per-direction FIFO depth in words (power of 2, 2..128).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on pio_ctrl_in[0].
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_clk  in  1  sole clock; reset_reset  in  1  synchronous active-high reset.
REQ-004 SHALL have pio_ctrl_in  in  32  HPS control word (from pp_out_lw_axi_export): [0] req toggle, [3:1] opcode, [4] data parity, rest ignored.
REQ-005 SHALL have pio_data_in  in  32  HPS write data (from pp_out_axi_export).
REQ-006 SHALL have pio_stat_out  out  32  status word (to pp_in_lw_axi_export).
REQ-007 SHALL have pio_data_out  out  32  read data (to pp_in_axi_export).
REQ-008 SHALL have tx_data  out  32, tx_valid  out  1, tx_ready  in  1: word stream to the fabric datapath.
REQ-009 SHALL have rx_data  in  32, rx_valid  in  1, rx_ready  out  1: word stream from the fabric datapath.

Function
REQ-010 SHALL detect a command when synchronized req differs from req_last; req_last updates in the same cycle.
REQ-011 SHALL run FSM IDLE -> EXEC (1 cycle) -> ACK (1 cycle) -> IDLE; ack bit pio_stat_out[0] toggles on the ACK cycle.
REQ-012 SHALL ignore further req edges while not IDLE; they are taken once IDLE is re-entered.
REQ-013 SHALL execute opcode 0 NOP: no side effect, ack only.
REQ-014 SHALL execute opcode 1 WRITE: push pio_data_in into TX FIFO; if full, drop the word and set sticky err_ovf.
REQ-015 SHALL execute opcode 2 READ: pop RX FIFO into pio_data_out; if empty, drive 0 and set sticky err_udf.
REQ-016 SHALL execute opcode 3 CLEAR: flush both FIFOs, clear all sticky errors, set pio_data_out to 0.
REQ-017 SHALL execute opcode 4 STATUS: pio_data_out = {16'b0, rx_count[7:0], tx_count[7:0]}.
REQ-018 SHALL treat opcodes 5-7 as no-ops, set sticky err_cmd, and still ack.
REQ-019 SHALL drive pio_stat_out as: [0] ack, [1] busy (FSM != IDLE), [2] tx_full, [3] rx_empty, [4] err_ovf, [5] err_udf, [6] err_cmd, [7] err_par, [15:8] tx_count, [23:16] rx_count, [31:24] 0.
REQ-020 SHALL drive tx_valid = TX FIFO not empty and tx_data = head word; it pops on tx_valid & tx_ready.
REQ-021 SHALL drive rx_ready = RX FIFO not full; it pushes on rx_valid & rx_ready.
REQ-022 SHALL allow a stream pop/push and a command push/pop in the same cycle, with counts correct; a CLEAR overrides a same-cycle stream transfer.
REQ-023 SHALL hold pio_data_out stable except on READ, STATUS or CLEAR execution.

Reset
REQ-024 SHALL reset FSM to IDLE, ack to 0, FIFOs to empty, sticky errors to 0, and pio_data_out to 0.
REQ-025 SHALL load req_last from the synchronizer output every reset cycle, so no command fires at reset release.
REQ-026 SHALL, on reset asserted mid-command, abandon the command with no FIFO change and no ack toggle.

Configuration
REQ-027 SHALL, with PIO_LINK_PARITY_EN defined, check on WRITE that pio_ctrl_in[4] equals the XOR of pio_data_in; on mismatch it drops the word, sets sticky err_par, and still acks.
REQ-028 SHALL, without PIO_LINK_PARITY_EN, ignore pio_ctrl_in[4] and hold err_par at 0.

Structure
REQ-029 SHALL place the opcode enum, the status bit-index constants and the parity function in package pio_link_pkg.
REQ-030 SHALL instantiate sub-module pio_link_fifo (sync FIFO with flush and count) twice, once for TX and once for RX.

Verification
REQ-031 Bench SHALL cover: WRITE 0x3F800000, req 0->1 -> tx_data=0x3F800000, tx_valid=1, ack toggles, tx_count=1.
REQ-032 Bench SHALL cover: rx_data=0x40490FDB pushed, then READ -> pio_data_out=0x40490FDB, rx_empty=1; second READ -> 0 and err_udf=1.
REQ-033 Bench SHALL cover: 17 WRITEs with DEPTH=16 and tx_ready=0 -> tx_full=1, tx_count=16, err_ovf=1, 17th word absent.
REQ-034 Bench SHALL cover: opcode 6 -> err_cmd=1 and ack toggles; then CLEAR -> all errors 0, counts 0.
REQ-035 Bench SHALL cover: with PIO_LINK_PARITY_EN, WRITE 0x00000001 with parity bit 0 -> err_par=1, tx_count unchanged.
REQ-036 Bench SHALL cover: reset asserted during EXEC with req held at 1 -> after release busy=0, ack=0, no spurious command.
